div_clk_select: RTL and testbench

- Glitch-free selector downstream of the even clock divider.
- Consumes the divider's registered div2/div4/div6 waveforms, which are synchronous to clk.
- Drives one selected divided waveform onto clk_out and switches sources only at safe low points: no truncated high, no runt pulse.
- A valid/ready request interface changes the selection; a rise-strobe output feeds downstream enable-based logic.

---
 rtl/div_clk_select_pkg.sv | 29 ++
 rtl/div_clk_select.sv | 96 +++++++++
 tb/tb_div_clk_select.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_clk_select_pkg.sv
// rtl/div_clk_select_pkg.sv - selection/state types and source mux for div_clk_select
package div_clk_select_pkg;

  typedef enum logic [1:0] {
    SEL_DIV2 = 2'd0,
    SEL_DIV4 = 2'd1,
    SEL_DIV6 = 2'd2,
    SEL_OFF  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    GAP,
    ARM
  } state_e;

  function automatic logic src_mux(sel_e s, logic d2, logic d4, logic d6);
    logic r;
    case (s)
      SEL_DIV2: r = d2;
      SEL_DIV4: r = d4;
      SEL_DIV6: r = d6;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_clk_select.sv
// rtl/div_clk_select.sv - glitch-free selector of div2/div4/div6 onto clk_out
// Switches only at low points: drain the old high, force a gap, arm on the new source's low.
module div_clk_select
  import div_clk_select_pkg::*;
#(
  parameter logic [1:0] RESET_SEL = 2'd0,
  parameter int         MIN_GAP   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       div2,
  input  logic       div4,
  input  logic       div6,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic       sel_done,
  output logic [1:0] cur_sel,
  output logic       switching,
  output logic       clk_out,
  output logic       clk_out_rise
);

  localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);

  state_e     state;
  sel_e       cur_q;
  sel_e       tgt_q;
  logic [3:0] gap_cnt;
  logic       src_cur;
  logic       src_tgt;
  logic       clk_nxt;
  logic       accept;

  assign src_cur = src_mux(cur_q, div2, div4, div6);
  assign src_tgt = src_mux(tgt_q, div2, div4, div6);
  assign accept  = sel_valid & sel_ready;
  assign cur_sel = cur_q;

  // DRAIN keeps following the old source so its high phase is never cut short
  assign clk_nxt = ((state == IDLE) || (state == DRAIN)) ? src_cur : 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cur_q        <= sel_e'(RESET_SEL);
      tgt_q        <= sel_e'(RESET_SEL);
      gap_cnt      <= 4'd0;
      clk_out      <= 1'b0;
      clk_out_rise <= 1'b0;
      sel_done     <= 1'b0;
      sel_ready    <= 1'b1;
      switching    <= 1'b0;
    end else begin
      clk_out      <= clk_nxt;
      clk_out_rise <= clk_nxt & ~clk_out;
      sel_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_e'(sel) == cur_q) begin
              sel_done <= 1'b1;
            end else begin
              tgt_q     <= sel_e'(sel);
              state     <= DRAIN;
              sel_ready <= 1'b0;
              switching <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!src_cur) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= ARM;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        ARM: begin
          // handing over while the new source is low makes its first high a full one
          if (!src_tgt) begin
            cur_q     <= tgt_q;
            sel_done  <= 1'b1;
            state     <= IDLE;
            sel_ready <= 1'b1;
            switching <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_clk_select.sv
// tb/tb_div_clk_select.sv - directed bench for div_clk_select behind an even divider
module tb_div_clk_select;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       div2, div4, div6;
  logic [3:0] dcnt;

  logic [1:0] sel_a = 2'd0, sel_b = 2'd0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       a_ready, a_done, a_sw, a_clk, a_rise;
  logic       b_ready, b_done, b_sw, b_clk, b_rise;
  logic [1:0] a_cur, b_cur;
  logic       use_b = 1'b0;

  logic       o_ready, o_done, o_sw, o_clk, o_rise;
  logic [1:0] o_cur;

  int n_vec = 0;
  int n_err = 0;

  logic wave[$];
  int   done_idx, done_cnt, sw_bad, rise_after;

  always #5 clk = ~clk;

  // even divider: div2 toggles every cycle, div4 every 2, div6 every 3
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt <= 4'd0;
      div2 <= 1'b0;
      div4 <= 1'b0;
      div6 <= 1'b0;
    end else begin
      dcnt <= (dcnt == 4'd11) ? 4'd0 : dcnt + 4'd1;
      div2 <= ~div2;
      if (dcnt[0]) div4 <= ~div4;
      if (dcnt == 4'd2 || dcnt == 4'd5 || dcnt == 4'd8 || dcnt == 4'd11) div6 <= ~div6;
    end
  end

  div_clk_select #(.RESET_SEL(2'd0), .MIN_GAP(1)) dut_a (
    .clk(clk), .resetn(resetn), .div2(div2), .div4(div4), .div6(div6),
    .sel(sel_a), .sel_valid(valid_a), .sel_ready(a_ready), .sel_done(a_done),
    .cur_sel(a_cur), .switching(a_sw), .clk_out(a_clk), .clk_out_rise(a_rise)
  );

  div_clk_select #(.RESET_SEL(2'd2), .MIN_GAP(4)) dut_b (
    .clk(clk), .resetn(resetn), .div2(div2), .div4(div4), .div6(div6),
    .sel(sel_b), .sel_valid(valid_b), .sel_ready(b_ready), .sel_done(b_done),
    .cur_sel(b_cur), .switching(b_sw), .clk_out(b_clk), .clk_out_rise(b_rise)
  );

  assign o_ready = use_b ? b_ready : a_ready;
  assign o_done  = use_b ? b_done  : a_done;
  assign o_sw    = use_b ? b_sw    : a_sw;
  assign o_clk   = use_b ? b_clk   : a_clk;
  assign o_rise  = use_b ? b_rise  : a_rise;
  assign o_cur   = use_b ? b_cur   : a_cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // issue a request at the current negedge and record clk_out until post cycles after sel_done
  task automatic run_switch(input logic [1:0] s, input int post);
    wave.delete();
    done_idx = -1; done_cnt = 0; sw_bad = 0; rise_after = 0;
    if (use_b) begin sel_b = s; valid_b = 1'b1; end
    else       begin sel_a = s; valid_a = 1'b1; end
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      wave.push_back(o_clk);
      if (o_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx < 0 && !o_sw) sw_bad++;
      if (done_idx >= 0 && i > done_idx && o_rise) rise_after++;
      if (done_idx >= 0 && i >= done_idx + post) break;
      @(negedge clk);
    end
    check("switch_completes", done_idx >= 0, 1);
  endtask

  function automatic int run_len(int idx);
    int l = idx;
    int r = idx;
    while (l > 0 && wave[l-1] == wave[idx]) l--;
    while (r < wave.size() - 1 && wave[r+1] == wave[idx]) r++;
    return r - l + 1;
  endfunction

  function automatic int bad_high_runs();
    int bad = 0;
    int i = 0;
    int n = wave.size();
    while (i < n && wave[i] == wave[0]) i++;
    while (i < n) begin
      int l;
      l = run_len(i);
      if (i + l < n && wave[i] == 1'b1 && l != 1 && l != 3) bad++;
      i += l;
    end
    return bad;
  endfunction

  initial begin
    logic p, pc;
    int   rises, dones, rdy_miss, j;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_clk_out", a_clk, 0);
    check("rst_rise", a_rise, 0);
    check("rst_done", a_done, 0);
    check("rst_switching", a_sw, 0);
    check("rst_ready", a_ready, 1);
    check("rst_cur_sel", a_cur, 0);
    check("rst_cur_sel_b", b_cur, 2);
    resetn = 1'b1;

    // div2 passthrough, one cycle late
    p = div2; pc = a_clk; rises = 0; dones = 0; rdy_miss = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("idle_follow_div2", a_clk, p);
      check("idle_rise", a_rise, a_clk & ~pc);
      rises += a_rise; dones += a_done; rdy_miss += !a_ready;
      p = div2; pc = a_clk;
    end
    check("idle_rise_count", rises, 12);
    check("idle_done_count", dones, 0);
    check("idle_ready_low", rdy_miss, 0);

    // div2 -> div6 accepted while div2 is high
    for (int i = 0; i < 4 && !div2; i++) @(negedge clk);
    run_switch(2'd2, 10);
    if (done_idx >= 0) begin
      check("d2d6_hold_high", wave[0], 1);
      check("d2d6_drop", wave[1], 0);
      j = 2;
      while (j < wave.size() - 1 && wave[j] == 1'b0) j++;
      check("d2d6_gap_ge2", run_len(1) >= 2, 1);
      check("d2d6_first_high3", run_len(j), 3);
      check("d2d6_latency", done_idx <= 7, 1);
    end
    check("d2d6_done_once", done_cnt, 1);
    check("d2d6_switching", sw_bad, 0);
    check("d2d6_cur_sel", a_cur, 2);

    // div6 -> div4, then a same-selection request
    run_switch(2'd1, 2);
    check("d6d4_done_once", done_cnt, 1);
    check("d6d4_cur_sel", a_cur, 1);
    check("d6d4_latency", done_idx <= 8, 1);
    sel_a = 2'd1; valid_a = 1'b1; p = div4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      valid_a = 1'b0;
      check("same_follow_div4", a_clk, p);
      check("same_done", a_done, (i == 0));
      check("same_switching", a_sw, 0);
      p = div4;
    end

    // div4 -> off
    run_switch(2'd3, 20);
    check("off_done_once", done_cnt, 1);
    check("off_cur_sel", a_cur, 3);
    check("off_latency", done_idx <= 5, 1);
    check("off_rise_after", rise_after, 0);
    if (done_idx >= 0) begin
      rises = 0;
      for (int i = done_idx; i < wave.size(); i++) rises += wave[i];
      check("off_stays_low", rises, 0);
    end

    // MIN_GAP=4: div6 -> div2
    use_b = 1'b1;
    run_switch(2'd0, 12);
    check("g4_done_once", done_cnt, 1);
    check("g4_cur_sel", b_cur, 0);
    check("g4_latency", done_idx <= 10, 1);
    check("g4_switching", sw_bad, 0);
    if (done_idx >= 0) begin
      check("g4_low_at_done", wave[done_idx], 0);
      check("g4_gap_ge5", run_len(done_idx) >= 5, 1);
    end
    check("g4_high_runs", bad_high_runs(), 0);
    use_b = 1'b0;

    // reset while draining a high phase
    run_switch(2'd2, 2);
    check("off_d6_cur_sel", a_cur, 2);
    for (int i = 0; i < 8 && !div6; i++) @(negedge clk);
    sel_a = 2'd0; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("drain_clk_high", a_clk, 1);
    check("drain_switching", a_sw, 1);
    resetn = 1'b0;
    #1;
    check("async_clk_out", a_clk, 0);
    check("async_cur_sel", a_cur, 0);
    check("async_switching", a_sw, 0);
    check("async_ready", a_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_switch(2'd1, 2);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_cur_sel", a_cur, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
